// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - baccarat round controller: deal sequencing, third-card rules, win lights
//
// Ports:
//   slow_clock        in   round clock, rising edge; same edge the datapath loads cards on
//   reset             in   asynchronous, active-high; forces state RST
//   pscore[3:0]       in   player hand score from datapath
//   dscore[3:0]       in   dealer hand score from datapath
//   pcard3[3:0]       in   player third-card value (0 = not dealt, 1..13)
//   load_pcard1..3    out  player card load strobes
//   load_dcard1..3    out  dealer card load strobes
//   player_win_light  out  player wins or tie (DONE only)
//   dealer_win_light  out  dealer wins or tie (DONE only)
//   done              out  round complete
module game_fsm #(
  parameter logic [3:0] NATURAL_MIN = 4'd8,
  parameter logic [3:0] STAND_MIN   = 4'd6
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_P1    = 4'd1,
    S_D1    = 4'd2,
    S_P2    = 4'd3,
    S_D2    = 4'd4,
    S_EVAL1 = 4'd5,
    S_P3    = 4'd6,
    S_EVAL2 = 4'd7,
    S_D3    = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t state;
  state_t next_state;

  // Face cards (10..13) are worth 0 when the dealer rule looks at the player's third card.
  logic [3:0] card_val;
  logic       dealer_draws;

  assign card_val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

  always_comb begin
    dealer_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (card_val != 4'd8);
      4'd4:             dealer_draws = (card_val >= 4'd2) && (card_val <= 4'd7);
      4'd5:             dealer_draws = (card_val >= 4'd4) && (card_val <= 4'd7);
      4'd6:             dealer_draws = (card_val >= 4'd6) && (card_val <= 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= next_state;
  end

  always_comb begin
    next_state       = S_RST;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    done             = 1'b0;
    case (state)
      S_RST: next_state = S_P1;
      S_P1: begin
        load_pcard1 = 1'b1;
        next_state  = S_D1;
      end
      S_D1: begin
        load_dcard1 = 1'b1;
        next_state  = S_P2;
      end
      S_P2: begin
        load_pcard2 = 1'b1;
        next_state  = S_D2;
      end
      S_D2: begin
        load_dcard2 = 1'b1;
        next_state  = S_EVAL1;
      end
      S_EVAL1: begin
        if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) next_state = S_DONE;
        else if (pscore < STAND_MIN)                        next_state = S_P3;
        else if (dscore < STAND_MIN)                        next_state = S_D3;
        else                                                next_state = S_DONE;
      end
      S_P3: begin
        load_pcard3 = 1'b1;
        next_state  = S_EVAL2;
      end
      S_EVAL2: next_state = dealer_draws ? S_D3 : S_DONE;
      S_D3: begin
        load_dcard3 = 1'b1;
        next_state  = S_DONE;
      end
      S_DONE: begin
        done             = 1'b1;
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
        next_state       = S_DONE;
      end
      default: next_state = S_RST;
    endcase
  end

endmodule

// File: tb/tb_game_fsm.sv
// tb/tb_game_fsm.sv - self-checking bench for game_fsm
module tb_game_fsm;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, done;

  int total = 0;
  int bad = 0;

  game_fsm dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .done             (done)
  );

  always #5 slow_clock = ~slow_clock;

  // {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}
  wire [5:0] loads = {load_pcard1, load_dcard1, load_pcard2,
                      load_dcard2, load_pcard3, load_dcard3};
  wire [8:0] outs  = {loads, player_win_light, dealer_win_light, done};

  typedef struct {
    logic [3:0] p;
    logic [3:0] d;
    logic [3:0] c3;
    logic       exp_p3;
    logic       exp_d3;
    logic       exp_pw;
    logic       exp_dw;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  // Reset between edges, release, then clock up to EVAL1 (5 edges).
  task automatic start_round(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c3);
    pscore = p;
    dscore = d;
    pcard3 = c3;
    reset  = 1'b1;
    #2;
    reset  = 1'b0;
    for (int k = 0; k < 5; k++) step();
  endtask

  task automatic run_vec(input int i);
    int   n;
    logic seen_p3, seen_d3, multi;
    string tag;
    tag = $sformatf("vec%0d", i);
    pscore = vecs[i].p;
    dscore = vecs[i].d;
    pcard3 = vecs[i].c3;
    reset  = 1'b1;
    #2;
    reset  = 1'b0;
    step();
    check({tag, "_p1"}, int'(loads), 6'b100000);
    n = 0;
    seen_p3 = 1'b0;
    seen_d3 = 1'b0;
    multi = 1'b0;
    while (!done && n < 20) begin
      step();
      n++;
      seen_p3 |= load_pcard3;
      seen_d3 |= load_dcard3;
      if ($countones(loads) > 1) multi = 1'b1;
    end
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_edges"}, n, 5 + (vecs[i].exp_p3 ? 2 : 0) + (vecs[i].exp_d3 ? 1 : 0));
    check({tag, "_p3"}, int'(seen_p3), int'(vecs[i].exp_p3));
    check({tag, "_d3"}, int'(seen_d3), int'(vecs[i].exp_d3));
    check({tag, "_pw"}, int'(player_win_light), int'(vecs[i].exp_pw));
    check({tag, "_dw"}, int'(dealer_win_light), int'(vecs[i].exp_dw));
    check({tag, "_onehot"}, int'(multi), 0);
  endtask

  initial begin
    //          p      d      c3     p3    d3    pw    dw
    vecs[0]  = '{4'd8, 4'd3, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4'd2, 4'd3, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{4'd2, 4'd6, 4'd7,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{4'd2, 4'd5, 4'd12, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{4'd2, 4'd4, 4'd2,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{4'd6, 4'd4, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{4'd7, 4'd7, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{4'd5, 4'd5, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{4'd3, 4'd0, 4'd13, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'd9, 4'd9, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{4'd4, 4'd3, 4'd10, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{4'd1, 4'd12, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{4'd0, 4'd7, 4'd6,  1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state and asynchronous reset mid-D1.
    #2;
    check("reset_outs", int'(outs), 0);
    reset = 1'b0;
    step();
    check("first_p1", int'(loads), 6'b100000);
    step();
    check("d1_before_reset", int'(loads), 6'b010000);
    reset = 1'b1;
    #1;
    check("async_reset_outs", int'(outs), 0);
    #1;
    reset = 1'b0;
    #1;
    check("released_no_edge", int'(outs), 0);
    step();
    check("p1_after_release", int'(loads), 6'b100000);

    // Strobe order with tied-zero scores, continuing from P1.
    step();
    check("order_d1", int'(outs), 9'b010000_000);
    step();
    check("order_p2", int'(outs), 9'b001000_000);
    step();
    check("order_d2", int'(outs), 9'b000100_000);
    step();
    check("order_eval1", int'(outs), 0);

    // Table-driven rounds.
    for (int i = 0; i < 13; i++) run_vec(i);

    // Player stands, dealer draws, then dealer score moves to 7.
    start_round(4'd6, 4'd4, 4'd0);
    check("stand_eval1", int'(outs), 0);
    step();
    check("stand_d3", int'(loads), 6'b000001);
    dscore = 4'd7;
    step();
    check("stand_done", int'(done), 1);
    check("stand_lights", int'({player_win_light, dealer_win_light}), 2'b01);

    // Tie and stickiness.
    start_round(4'd5, 4'd5, 4'd0);
    step();
    check("tie_p3", int'(loads), 6'b000010);
    step();
    check("tie_eval2", int'(outs), 0);
    step();
    check("tie_done", int'(outs), 9'b000000_111);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("sticky%0d", k), int'(outs), 9'b000000_111);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
